// File: rtl/watchdog.sv
// Watchdog timer with a small register interface.
// A prescaler divides i_clock into ticks; each tick decrements a 16-bit counter.
// Reaching half the reload value raises an early-warning interrupt.
// Reaching zero, or writing a wrong kick key, fires a fixed-length reset request.
// Bus writes are captured on the accepting edge and applied on the following edge,
// so their effect becomes visible the cycle after o_ready.
module watchdog #(
    parameter int unsigned PRESCALE       = 1000,
    parameter logic [15:0] DEFAULT_RELOAD = 16'hFFFF,
    parameter int unsigned RESET_PULSE    = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [1:0]  i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_interrupt,
    output logic        o_reset_request
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int RW = (RESET_PULSE > 1) ? $clog2(RESET_PULSE) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
    localparam logic [RW-1:0] PULSE_LAST = RW'(RESET_PULSE - 1);
    localparam logic [31:0]   KICK_KEY   = 32'h5A5AA5A5;

    localparam logic [1:0] ADDR_CONTROL = 2'd0;
    localparam logic [1:0] ADDR_RELOAD  = 2'd1;
    localparam logic [1:0] ADDR_KICK    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd1;
    localparam logic [1:0] CAUSE_BAD_KICK = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WARN = 2'd2,
        ST_FIRE = 2'd3
    } state_t;

    state_t        state_q,   state_d;
    logic          enable_q,  enable_d;
    logic          lock_q,    lock_d;
    logic [15:0]   reload_q,  reload_d;
    logic [15:0]   counter_q, counter_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic [RW-1:0] pulse_q,   pulse_d;
    logic [1:0]    cause_q,   cause_d;
    logic          ready_q,   ready_d;
    logic [31:0]   rdata_q,   rdata_d;
    logic          irq_q,     irq_d;
    logic          rstreq_q,  rstreq_d;
    logic          wr_q,      wr_d;
    logic [1:0]    addr_q,    addr_d;
    logic [31:0]   wdata_q,   wdata_d;

    logic        accept;
    logic        commit;
    logic        ctrl_wr;
    logic        reload_wr;
    logic        kick_wr;
    logic        kick_good;
    logic        tick;
    logic [15:0] dec;

    // Access decode: a new request is taken only when the previous ack has ended;
    // the captured write is applied during the ack cycle.
    assign accept    = i_request && !ready_q;
    assign commit    = ready_q && wr_q;
    assign ctrl_wr   = commit && (addr_q == ADDR_CONTROL) && !lock_q;
    assign reload_wr = commit && (addr_q == ADDR_RELOAD) && !lock_q && (wdata_q[15:0] != 16'd0);
    assign kick_wr   = commit && (addr_q == ADDR_KICK);
    assign kick_good = (wdata_q == KICK_KEY);
    assign tick      = (presc_q == PRE_LAST);
    assign dec       = (counter_q != 16'd0) ? (counter_q - 16'd1) : 16'd0;

    // Next-state logic for the bus interface, registers and watchdog FSM.
    always_comb begin
        state_d   = state_q;
        enable_d  = enable_q;
        lock_d    = lock_q;
        reload_d  = reload_q;
        counter_d = counter_q;
        presc_d   = presc_q;
        pulse_d   = pulse_q;
        cause_d   = cause_q;
        ready_d   = 1'b0;
        rdata_d   = 32'd0;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        if (accept) begin
            ready_d = 1'b1;
            wr_d    = i_rw;
            addr_d  = i_address;
            wdata_d = i_wdata;
            if (!i_rw) begin
                case (i_address)
                    ADDR_CONTROL: rdata_d = {30'd0, lock_q, enable_q};
                    ADDR_RELOAD:  rdata_d = {16'd0, reload_q};
                    ADDR_KICK:    rdata_d = 32'd0;
                    ADDR_STATUS:  rdata_d = {14'd0, cause_q, counter_q};
                    default:      rdata_d = 32'd0;
                endcase
            end
        end

        if (reload_wr) begin
            reload_d = wdata_q[15:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_wr) begin
                    enable_d = wdata_q[0];
                    lock_d   = lock_q | wdata_q[1];
                    if (wdata_q[0] && !enable_q) begin
                        counter_d = reload_q;
                        presc_d   = '0;
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_RUN, ST_WARN: begin
                if (ctrl_wr) begin
                    enable_d = wdata_q[0];
                    lock_d   = lock_q | wdata_q[1];
                end
                if (ctrl_wr && !wdata_q[0]) begin
                    // Disable freezes counter and prescaler where they are.
                    state_d = ST_IDLE;
                end else if (kick_wr && kick_good) begin
                    // A good kick overrides any tick landing on the same edge.
                    counter_d = reload_q;
                    presc_d   = '0;
                    state_d   = ST_RUN;
                end else if (kick_wr) begin
                    cause_d = CAUSE_BAD_KICK;
                    pulse_d = '0;
                    state_d = ST_FIRE;
                end else begin
                    presc_d = tick ? '0 : (presc_q + PW'(1));
                    if (tick) begin
                        counter_d = dec;
                        if (dec == 16'd0) begin
                            cause_d = CAUSE_TIMEOUT;
                            pulse_d = '0;
                            state_d = ST_FIRE;
                        end else if (dec == (reload_q >> 1)) begin
                            state_d = ST_WARN;
                        end
                    end
                end
            end
            ST_FIRE: begin
                // Enable cannot be changed while firing; lock may still be set.
                if (ctrl_wr) begin
                    lock_d = lock_q | wdata_q[1];
                end
                if (pulse_q == PULSE_LAST) begin
                    enable_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    pulse_d = pulse_q + RW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        irq_d    = (state_d == ST_WARN);
        rstreq_d = (state_d == ST_FIRE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            enable_q  <= 1'b0;
            lock_q    <= 1'b0;
            reload_q  <= DEFAULT_RELOAD;
            counter_q <= 16'd0;
            presc_q   <= '0;
            pulse_q   <= '0;
            cause_q   <= 2'd0;
            ready_q   <= 1'b0;
            rdata_q   <= 32'd0;
            irq_q     <= 1'b0;
            rstreq_q  <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= 2'd0;
            wdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            lock_q    <= lock_d;
            reload_q  <= reload_d;
            counter_q <= counter_d;
            presc_q   <= presc_d;
            pulse_q   <= pulse_d;
            cause_q   <= cause_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
            rstreq_q  <= rstreq_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign o_rdata         = rdata_q;
    assign o_ready         = ready_q;
    assign o_interrupt     = irq_q;
    assign o_reset_request = rstreq_q;

endmodule

// File: tb/tb_watchdog.sv
// Testbench for the watchdog: directed scenarios plus a randomized kick phase
// checked against a time-since-arm reference model.
module tb_watchdog;

    localparam int P     = 4;
    localparam int PULSE = 4;
    localparam logic [31:0] KEY = 32'h5A5AA5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;
    logic        rreq;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state for the randomized phase
    int R, RP, e, kind, n, m;
    bit armed, stage, commit, exp_run, exp_fire, exp_irq;
    logic [31:0] d;

    watchdog #(
        .PRESCALE(P),
        .DEFAULT_RELOAD(16'hFFFF),
        .RESET_PULSE(PULSE)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_request(req),
        .i_rw(rw),
        .i_address(addr),
        .i_wdata(wdata),
        .o_rdata(rdata),
        .o_ready(ready),
        .o_interrupt(irq),
        .o_reset_request(rreq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the write has been applied.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] dat);
        req = 1'b1; rw = 1'b1; addr = a; wdata = dat;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; data reflects state at the call time.
    task automatic bus_read(input logic [1:0] a, output logic [31:0] dat);
        req = 1'b1; rw = 1'b0; addr = a; wdata = 32'd0;
        @(negedge clk);
        check("read_ack", 32'(ready), 32'd1);
        dat = rdata;
        req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        rst = 1'b1; req = 1'b0; rw = 1'b0; addr = 2'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq",   32'(irq), 32'd0);
        check("rst_rreq",  32'(rreq), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        bus_read(2'd0, d); check("rst_control", d, 32'd0);
        bus_read(2'd1, d); check("rst_reload",  d, 32'h0000FFFF);
        bus_read(2'd3, d); check("rst_status",  d, 32'd0);
        bus_read(2'd2, d); check("kick_reads0", d, 32'd0);

        // held request: ack 1, then 0, then a fresh ack
        req = 1'b1; rw = 1'b0; addr = 2'd1;
        @(negedge clk); check("hold_ack1", 32'(ready), 32'd1); check("hold_data", rdata, 32'h0000FFFF);
        @(negedge clk); check("hold_ack_gap", 32'(ready), 32'd0);
        @(negedge clk); check("hold_ack2", 32'(ready), 32'd1);
        req = 1'b0;
        @(negedge clk); check("hold_ack_end", 32'(ready), 32'd0);

        // reload of zero ignored; only low 16 bits stored
        bus_write(2'd1, 32'd0);
        bus_read(2'd1, d); check("reload_zero_ign", d, 32'h0000FFFF);
        bus_write(2'd1, 32'hABCD0008);
        bus_read(2'd1, d); check("reload_low16", d, 32'd8);

        // timeout without kicks
        bus_write(2'd0, 32'd1);
        n = 0;
        while (irq !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("to_irq_cycles", 32'(n), 32'd16);
        while (rreq !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("to_fire_cycles", 32'(n), 32'd32);
        check("to_irq_in_fire", 32'(irq), 32'd0);
        m = 0;
        while (rreq === 1'b1 && m < 50) begin m++; @(negedge clk); end
        check("to_pulse_len", 32'(m), 32'd4);
        bus_read(2'd3, d); check("to_status", d, 32'h00010000);
        bus_read(2'd0, d); check("to_control", d, 32'd0);

        // bad kick
        bus_write(2'd0, 32'd1);
        repeat (5) @(negedge clk);
        req = 1'b1; rw = 1'b1; addr = 2'd2; wdata = 32'h12345678;
        @(negedge clk);
        check("bk_ack", 32'(ready), 32'd1);
        check("bk_rreq_ack_cycle", 32'(rreq), 32'd0);
        req = 1'b0;
        @(negedge clk);
        check("bk_rreq_next", 32'(rreq), 32'd1);
        m = 0;
        while (rreq === 1'b1 && m < 50) begin m++; @(negedge clk); end
        check("bk_pulse_len", 32'(m), 32'd4);
        bus_read(2'd3, d); check("bk_cause", 32'(d[17:16]), 32'd2);

        // kick landing on the final tick edge
        bus_write(2'd0, 32'd1);
        repeat (28) @(negedge clk);
        bus_read(2'd3, d); check("edge_cnt_before", d, 32'h00020001);
        bus_write(2'd2, KEY);
        check("edge_no_fire", 32'(rreq), 32'd0);
        bus_read(2'd3, d); check("edge_cnt_after", d, 32'h00020008);
        repeat (2) @(negedge clk);
        check("edge_no_fire_late", 32'(rreq), 32'd0);
        bus_write(2'd0, 32'd0);

        // periodic good kicks every 20 cycles
        bus_write(2'd0, 32'd1);
        for (int k = 0; k < 50; k++) begin
            for (int j = 0; j < 18; j++) begin
                @(negedge clk);
                check("per_no_fire", 32'(rreq), 32'd0);
            end
            check("per_irq_before", 32'(irq), 32'd1);
            bus_write(2'd2, KEY);
            check("per_irq_after", 32'(irq), 32'd0);
        end
        bus_write(2'd0, 32'd0);

        // randomized kicks against the time-since-arm model
        R  = $urandom_range(2, 10);
        RP = R * P;
        bus_write(2'd1, 32'(R));
        armed = 1'b0; e = 0; stage = 1'b0; kind = 0;
        for (int c = 0; c < 3000; c++) begin
            exp_run  = armed && (e < RP);
            exp_fire = armed && (e >= RP) && (e < RP + PULSE);
            exp_irq  = exp_run && ((R - e / P) <= (R >> 1));
            check("rnd_rreq", 32'(rreq), 32'(exp_fire));
            check("rnd_irq",  32'(irq),  32'(exp_irq));
            commit = stage;
            if (stage) begin
                req = 1'b0;
                stage = 1'b0;
            end else if ($urandom_range(0, 24) == 0) begin
                rw = 1'b1;
                if (!exp_run && !exp_fire) begin
                    kind = 0; addr = 2'd0; wdata = 32'd1;
                end else if ($urandom_range(0, 5) == 0) begin
                    kind = 2; addr = 2'd2; wdata = $urandom();
                    if (wdata == KEY) wdata = wdata ^ 32'd1;
                end else begin
                    kind = 1; addr = 2'd2; wdata = KEY;
                end
                req = 1'b1;
                stage = 1'b1;
            end
            if (commit && kind == 0 && !exp_run && !exp_fire) begin
                armed = 1'b1; e = 0;
            end else if (commit && kind == 1 && exp_run) begin
                e = 0;
            end else if (commit && kind == 2 && exp_run) begin
                e = RP;
            end else begin
                e++;
            end
            @(negedge clk);
        end
        req = 1'b0;
        @(negedge clk);

        // lock, then reset during the pulse
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        bus_write(2'd1, 32'd8);
        bus_write(2'd0, 32'd3);
        bus_write(2'd0, 32'd0);
        bus_write(2'd1, 32'd100);
        bus_read(2'd1, d); check("lock_reload", d, 32'd8);
        bus_read(2'd0, d); check("lock_control", d, 32'd3);
        n = 8;
        while (rreq !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("lock_fire_cycles", 32'(n), 32'd32);
        @(negedge clk);
        check("fire_cycle2", 32'(rreq), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_rreq",  32'(rreq), 32'd0);
        check("arst_ready", 32'(ready), 32'd0);
        check("arst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_read(2'd3, d); check("arst_status", d, 32'd0);
        bus_read(2'd1, d); check("arst_reload", d, 32'h0000FFFF);
        bus_read(2'd0, d); check("arst_control", d, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
